// File: rtl/memory_gap_profiler.sv
// memory_gap_profiler: per-channel idle-gap measurement between a response and the next request,
// emitted as one-cycle samples alongside running min/max/sum/count statistics.
module memory_gap_profiler #(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 16,
  parameter int SUM_W          = 32,
  parameter int NUM_W          = 16,
  parameter bit RESET_COUNTING = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         mem_req,
  input  logic [N_CH-1:0]         mem_rvalid,
  input  logic                    stats_clear,
  output logic [N_CH*CNT_W-1:0]   gap,
  output logic [N_CH-1:0]         gap_valid,
  output logic [N_CH-1:0]         gap_sat,
  output logic [N_CH*CNT_W-1:0]   gap_min,
  output logic [N_CH*CNT_W-1:0]   gap_max,
  output logic [N_CH*SUM_W-1:0]   gap_sum,
  output logic [N_CH*NUM_W-1:0]   gap_num
);
  typedef enum logic {IDLE, COUNT} state_e;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e            state_q;
    logic [CNT_W-1:0]  idle_q, gap_q, min_q, max_q, min_d, max_d, g;
    logic [SUM_W-1:0]  sum_q, sum_d, sum_b;
    logic [NUM_W-1:0]  num_q, num_d, num_b;
    logic [SUM_W:0]    sum_x;
    logic [NUM_W:0]    num_x;
    logic              valid_q, sat_q, emit;
    // A clear on the same edge as an emit makes the sample land in freshly cleared stats
    always_comb begin
      emit  = mem_req[c] & (state_q == COUNT | mem_rvalid[c]);
      g     = state_q == COUNT ? idle_q : '0;
      sum_b = stats_clear ? '0 : sum_q;
      num_b = stats_clear ? '0 : num_q;
      min_d = stats_clear ? (emit ? g : '1) : (emit && g < min_q ? g : min_q);
      max_d = stats_clear ? (emit ? g : '0) : (emit && g > max_q ? g : max_q);
      sum_x = {1'b0, sum_b} + (SUM_W+1)'(emit ? g : '0);
      sum_d = sum_x[SUM_W] ? '1 : sum_x[SUM_W-1:0];
      num_x = {1'b0, num_b} + (NUM_W+1)'(emit);
      num_d = num_x[NUM_W] ? '1 : num_x[NUM_W-1:0];
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= RESET_COUNTING ? COUNT : IDLE;
        idle_q  <= '0;
        gap_q   <= '0;
        valid_q <= 1'b0;
        sat_q   <= 1'b0;
        min_q   <= '1;
        max_q   <= '0;
        sum_q   <= '0;
        num_q   <= '0;
      end else begin
        valid_q <= emit;
        sat_q   <= emit & (&g);
        if (emit) gap_q <= g;
        min_q   <= min_d;
        max_q   <= max_d;
        sum_q   <= sum_d;
        num_q   <= num_d;
        if (state_q == IDLE) begin
          if (mem_rvalid[c] & ~mem_req[c]) begin
            state_q <= COUNT;
            idle_q  <= '0;
          end
        end else if (mem_req[c]) state_q <= IDLE;
        else idle_q <= mem_rvalid[c] ? '0 : idle_q + CNT_W'(~&idle_q);
      end
    end
    assign gap[c*CNT_W +: CNT_W]     = gap_q;
    assign gap_valid[c]              = valid_q;
    assign gap_sat[c]                = sat_q;
    assign gap_min[c*CNT_W +: CNT_W] = min_q;
    assign gap_max[c*CNT_W +: CNT_W] = max_q;
    assign gap_sum[c*SUM_W +: SUM_W] = sum_q;
    assign gap_num[c*NUM_W +: NUM_W] = num_q;
  end
endmodule

// File: tb/tb_memory_gap_profiler.sv
// tb_memory_gap_profiler: directed vectors, corner sequences and randomized traffic against
// a timestamp-based reference model, on a default instance and a narrow saturating instance.
module tb_memory_gap_profiler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stats_clear = 1'b0;
  logic [1:0] req_a = '0, rv_a = '0, req_b = '0, rv_b = '0;
  logic [31:0] gap_a, min_a, max_a, num_a;
  logic [63:0] sum_a;
  logic [1:0]  gv_a, sat_a, gv_b, sat_b;
  logic [7:0]  gap_b, min_b, max_b, num_b;
  logic [15:0] sum_b;
  int tests = 0, fails = 0;
  longint t = 0;

  always #5 clk = ~clk;

  memory_gap_profiler dut_a (
    .clk(clk), .rst_n(rst_n), .mem_req(req_a), .mem_rvalid(rv_a), .stats_clear(stats_clear),
    .gap(gap_a), .gap_valid(gv_a), .gap_sat(sat_a), .gap_min(min_a), .gap_max(max_a),
    .gap_sum(sum_a), .gap_num(num_a));

  memory_gap_profiler #(.CNT_W(4), .SUM_W(8), .NUM_W(4), .RESET_COUNTING(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_req(req_b), .mem_rvalid(rv_b), .stats_clear(stats_clear),
    .gap(gap_b), .gap_valid(gv_b), .gap_sat(sat_b), .gap_min(min_b), .gap_max(max_b),
    .gap_sum(sum_b), .gap_num(num_b));

  // Model: remember when the last response (or reset) happened; a gap is elapsed cycles minus one
  typedef struct {
    bit     armed, gv, sat;
    longint t_last, gap, mn, mx, sum, num;
  } mdl_t;
  mdl_t ma[2], mb[2];

  task automatic step(inout mdl_t m, input bit rq, input bit rv, input longint gmax,
                      input longint smax, input longint nmax, input bit rc);
    longint g;
    bit e;
    if (!rst_n) begin
      m.armed = rc; m.t_last = t; m.gv = 0; m.sat = 0; m.gap = 0;
      m.mn = gmax; m.mx = 0; m.sum = 0; m.num = 0;
      return;
    end
    e = 0; g = 0;
    if (m.armed && rq) begin
      e = 1; g = t - m.t_last - 1; if (g > gmax) g = gmax; m.armed = 0;
    end else if (m.armed && rv) m.t_last = t;
    else if (rv && rq) e = 1;
    else if (rv) begin m.armed = 1; m.t_last = t; end
    m.gv = e; m.sat = e && g == gmax;
    if (e) m.gap = g;
    if (stats_clear) begin m.mn = gmax; m.mx = 0; m.sum = 0; m.num = 0; end
    if (e) begin
      if (g < m.mn) m.mn = g;
      if (g > m.mx) m.mx = g;
      m.sum = m.sum + g > smax ? smax : m.sum + g;
      m.num = m.num + 1 > nmax ? nmax : m.num + 1;
    end
  endtask

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", n, act, exp, t);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("A%0d.gap", c), 64'(gap_a[c*16 +: 16]), ma[c].gap);
      chk($sformatf("A%0d.valid", c), 64'(gv_a[c]), 64'(ma[c].gv));
      chk($sformatf("A%0d.sat", c), 64'(sat_a[c]), 64'(ma[c].sat));
      chk($sformatf("A%0d.min", c), 64'(min_a[c*16 +: 16]), ma[c].mn);
      chk($sformatf("A%0d.max", c), 64'(max_a[c*16 +: 16]), ma[c].mx);
      chk($sformatf("A%0d.sum", c), 64'(sum_a[c*32 +: 32]), ma[c].sum);
      chk($sformatf("A%0d.num", c), 64'(num_a[c*16 +: 16]), ma[c].num);
      chk($sformatf("B%0d.gap", c), 64'(gap_b[c*4 +: 4]), mb[c].gap);
      chk($sformatf("B%0d.valid", c), 64'(gv_b[c]), 64'(mb[c].gv));
      chk($sformatf("B%0d.sat", c), 64'(sat_b[c]), 64'(mb[c].sat));
      chk($sformatf("B%0d.min", c), 64'(min_b[c*4 +: 4]), mb[c].mn);
      chk($sformatf("B%0d.max", c), 64'(max_b[c*4 +: 4]), mb[c].mx);
      chk($sformatf("B%0d.sum", c), 64'(sum_b[c*8 +: 8]), mb[c].sum);
      chk($sformatf("B%0d.num", c), 64'(num_b[c*4 +: 4]), mb[c].num);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      step(ma[c], req_a[c], rv_a[c], 65535, 64'hFFFF_FFFF, 65535, 1'b1);
      step(mb[c], req_b[c], rv_b[c], 15, 255, 15, 1'b0);
    end
    t++;
    #1;
    check_all();
  endtask

  typedef struct {
    bit     rn, rq, rv, clr, gv;
    longint gap, num, mn, mx, sum;
  } row_t;
  row_t rows[$];

  function automatic void add(bit rn, bit rq, bit rv, bit clr, bit gv, longint gap,
                              longint num, longint mn, longint mx, longint sum);
    row_t r;
    r.rn = rn; r.rq = rq; r.rv = rv; r.clr = clr; r.gv = gv;
    r.gap = gap; r.num = num; r.mn = mn; r.mx = mx; r.sum = sum;
    rows.push_back(r);
  endfunction

  initial begin
    // Directed vectors for channel 0 of the default instance
    add(0,0,0,0, 0,0,0,65535,0,0);
    add(0,0,0,0, 0,0,0,65535,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0, 0,0,0,65535,0,0);
    add(1,1,0,0, 1,3,1,3,3,3);
    add(1,0,0,0, 0,3,1,3,3,3);
    add(1,0,1,1, 0,3,0,65535,0,0);
    for (int i = 0; i < 5; i++) add(1,0,0,0, 0,3,0,65535,0,0);
    add(1,1,0,0, 1,5,1,5,5,5);
    add(1,1,1,0, 1,0,2,0,5,5);
    add(1,0,1,0, 0,0,2,0,5,5);
    for (int i = 0; i < 9; i++) add(1,0,0,0, 0,0,2,0,5,5);
    add(1,1,0,1, 1,9,1,9,9,9);
    add(1,0,0,1, 0,9,0,65535,0,0);
    add(1,0,1,0, 0,9,0,65535,0,0);
    for (int i = 0; i < 10; i++) add(1,0,0,0, 0,9,0,65535,0,0);
    add(0,1,0,0, 0,0,0,65535,0,0);
    add(1,0,0,0, 0,0,0,65535,0,0);
    foreach (rows[i]) begin
      rst_n = rows[i].rn; req_a[0] = rows[i].rq; rv_a[0] = rows[i].rv; stats_clear = rows[i].clr;
      cyc();
      chk($sformatf("row%0d.valid", i), 64'(gv_a[0]), 64'(rows[i].gv));
      chk($sformatf("row%0d.gap", i), 64'(gap_a[15:0]), rows[i].gap);
      chk($sformatf("row%0d.num", i), 64'(num_a[15:0]), rows[i].num);
      chk($sformatf("row%0d.min", i), 64'(min_a[15:0]), rows[i].mn);
      chk($sformatf("row%0d.max", i), 64'(max_a[15:0]), rows[i].mx);
      chk($sformatf("row%0d.sum", i), 64'(sum_a[31:0]), rows[i].sum);
    end
    req_a = '0; rv_a = '0; stats_clear = 0;
    // Saturating gap on the narrow instance, then a small gap
    rv_b[0] = 1; cyc(); rv_b[0] = 0;
    repeat (40) cyc();
    req_b[0] = 1; cyc(); req_b[0] = 0;
    chk("sat.valid", 64'(gv_b[0]), 1);
    chk("sat.gap", 64'(gap_b[3:0]), 15);
    chk("sat.flag", 64'(sat_b[0]), 1);
    rv_b[0] = 1; cyc(); rv_b[0] = 0;
    cyc(); cyc();
    req_b[0] = 1; cyc(); req_b[0] = 0;
    chk("small.gap", 64'(gap_b[3:0]), 2);
    chk("small.sat", 64'(sat_b[0]), 0);
    chk("small.sum", 64'(sum_b[7:0]), 17);
    chk("small.num", 64'(num_b[3:0]), 2);
    // Two channels with different gaps, requests on the same edge
    rv_a[1] = 1; cyc(); rv_a[1] = 0;
    repeat (3) cyc();
    rv_a[0] = 1; cyc(); rv_a[0] = 0;
    repeat (3) cyc();
    req_a = 2'b11; cyc(); req_a = '0;
    chk("dual.valid", 64'(gv_a), 3);
    chk("dual.gap0", 64'(gap_a[15:0]), 3);
    chk("dual.gap1", 64'(gap_a[31:16]), 7);
    cyc();
    chk("dual.pulse", 64'(gv_a), 0);
    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 599) != 0;
      stats_clear = $urandom_range(0, 79) == 0;
      for (int c = 0; c < 2; c++) begin
        req_a[c] = $urandom_range(0, 99) < 15;
        rv_a[c]  = $urandom_range(0, 99) < 20;
        req_b[c] = $urandom_range(0, 99) < (c == 0 ? 3 : 25);
        rv_b[c]  = $urandom_range(0, 99) < (c == 0 ? 3 : 25);
      end
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
